// File: rtl/scratch_pkg.sv
// Shared types and sizes for the palette PROM download writer.
package scratch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    TAIL = 2'd2
  } state_e;

  localparam int PALETTE_BYTES = 512;
  localparam int IOCTL_AW      = 22;

endpackage

// File: rtl/scratch_prom_loader_if.sv
// Download byte stream in, PROM write port out; master is the HPS side.
interface scratch_prom_loader_if;
  import scratch_pkg::*;

  logic                downloading;
  logic [IOCTL_AW-1:0] ioctl_addr;
  logic [7:0]          ioctl_dout;
  logic                ioctl_wr;
  logic [8:0]          prog_addr;
  logic [7:0]          prog_data;
  logic                prom_we;

  modport master (
    output downloading, ioctl_addr, ioctl_dout, ioctl_wr,
    input  prog_addr, prog_data, prom_we
  );

  modport slave (
    input  downloading, ioctl_addr, ioctl_dout, ioctl_wr,
    output prog_addr, prog_data, prom_we
  );

endinterface

// File: rtl/scratch_prom_loader.sv
// Filters the ioctl download stream into a window and emits registered PROM
// write strobes, with byte count, checksum and done/error status.
module scratch_prom_loader
  import scratch_pkg::*;
#(
  parameter logic [IOCTL_AW-1:0] PROM_START = '0,
  parameter int                  PROM_LEN   = PALETTE_BYTES,
  parameter int                  BUSY_TAIL  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  scratch_prom_loader_if.slave  bus,
  output logic                  dwnld_busy,
  output logic [9:0]            byte_count,
  output logic [7:0]            checksum,
  output logic                  prom_done,
  output logic                  prom_err
);

  localparam logic [IOCTL_AW-1:0] WIN_LEN    = IOCTL_AW'(PROM_LEN);
  localparam logic [9:0]          FULL_COUNT = 10'(PROM_LEN);
  localparam logic [3:0]          TAIL_LAST  = 4'(BUSY_TAIL - 1);

  state_e              state_q, state_d;
  logic [3:0]          tail_q, tail_d;
  logic [8:0]          prog_addr_q, prog_addr_d;
  logic [7:0]          prog_data_q, prog_data_d;
  logic                prom_we_q, prom_we_d;
  logic                busy_q, busy_d;
  logic [9:0]          count_q, count_d;
  logic [7:0]          sum_q, sum_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [IOCTL_AW:0]   offset;
  logic                in_window;
  logic                accept;

  always_comb begin
    // Extra top bit acts as the borrow, so addresses below the window never wrap in.
    offset    = {1'b0, bus.ioctl_addr} - {1'b0, PROM_START};
    in_window = !offset[IOCTL_AW] && (offset[IOCTL_AW-1:0] < WIN_LEN);
    accept    = (state_q == LOAD) && bus.ioctl_wr && in_window;

    state_d     = state_q;
    tail_d      = tail_q;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    prom_we_d   = 1'b0;
    count_d     = count_q;
    sum_d       = sum_q;
    done_d      = done_q;
    err_d       = err_q;

    if (accept) begin
      prom_we_d   = 1'b1;
      prog_addr_d = offset[8:0];
      prog_data_d = bus.ioctl_dout;
      sum_d       = sum_q + bus.ioctl_dout;
      if (count_q != 10'h3FF) begin
        count_d = count_q + 10'd1;
      end
    end

    // Entering LOAD only happens from IDLE/TAIL, where accept is never true.
    unique case (state_q)
      IDLE: begin
        if (bus.downloading) begin
          state_d = LOAD;
          count_d = '0;
          sum_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (!bus.downloading) begin
          state_d = TAIL;
          tail_d  = TAIL_LAST;
        end
      end
      TAIL: begin
        if (bus.downloading) begin
          state_d = LOAD;
          count_d = '0;
          sum_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end else if (tail_q == 4'd0) begin
          state_d = IDLE;
          done_d  = (count_q == FULL_COUNT);
          err_d   = (count_q != FULL_COUNT);
        end else begin
          tail_d = tail_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tail_q      <= '0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prom_we_q   <= 1'b0;
      busy_q      <= 1'b0;
      count_q     <= '0;
      sum_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tail_q      <= tail_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      prom_we_q   <= prom_we_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.prog_addr = prog_addr_q;
  assign bus.prog_data = prog_data_q;
  assign bus.prom_we   = prom_we_q;
  assign dwnld_busy    = busy_q;
  assign byte_count    = count_q;
  assign checksum      = sum_q;
  assign prom_done     = done_q;
  assign prom_err      = err_q;

endmodule
